// File: rtl/operand_loader_pkg.sv
// Shared types and defaults for the serial operand pair loader.
package operand_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_A = 2'd1,
        SHIFT_B = 2'd2,
        PRESENT = 2'd3
    } loader_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shadow register with synchronous clear and shift enable.
module sipo_shift #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // LSB-first streams enter at the MSB and walk down to bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (LSB_FIRST) begin
                q <= {din, q[WIDTH-1:1]};
            end else begin
                q <= {q[WIDTH-2:0], din};
            end
        end
    end

endmodule

// File: rtl/operand_pair_loader.sv
// Assembles operands A then B from a serial stream and presents them with a
// registered valid/ready handshake plus the combined LSB flag.
module operand_pair_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             lsb_or,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    loader_state_t    state;
    loader_state_t    state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             clr_c;
    logic             en_a_c;
    logic             en_b_c;
    logic             load_c;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_shift_c;
    logic             last_bit_c;

    sipo_shift #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_shift_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_c),
        .en    (en_a_c),
        .din   (ser_in),
        .q     (a_q)
    );

    sipo_shift #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_shift_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_c),
        .en    (en_b_c),
        .din   (ser_in),
        .q     (b_q)
    );

    // B shadow including the bit being accepted this cycle, for the output load
    always_comb begin
        b_shift_c = '0;
        if (LSB_FIRST) begin
            b_shift_c = {ser_in, b_q[WIDTH-1:1]};
        end else begin
            b_shift_c = {b_q[WIDTH-2:0], ser_in};
        end
    end

    assign last_bit_c = (cnt == CW'(WIDTH - 1));

    // Next-state and shadow control; abort overrides everything
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_c     = 1'b0;
        en_a_c    = 1'b0;
        en_b_c    = 1'b0;
        load_c    = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            clr_c     = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = SHIFT_A;
                        cnt_nxt   = '0;
                        clr_c     = 1'b1;
                    end
                end
                SHIFT_A: begin
                    if (ser_valid) begin
                        en_a_c = 1'b1;
                        if (last_bit_c) begin
                            state_nxt = SHIFT_B;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                SHIFT_B: begin
                    if (ser_valid) begin
                        en_b_c  = 1'b1;
                        cnt_nxt = cnt + CW'(1);
                        if (last_bit_c) begin
                            state_nxt = PRESENT;
                            load_c    = 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; the pair survives handshake and abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_out     <= '0;
            b_out     <= '0;
            lsb_or    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_valid <= (state_nxt == PRESENT);
            busy      <= (state_nxt != IDLE);
            if (load_c) begin
                a_out  <= a_q;
                b_out  <= b_shift_c;
                lsb_or <= a_q[0] | b_shift_c[0];
            end
        end
    end

endmodule

// File: tb/tb_operand_pair_loader.sv
// Self-checking bench for operand_pair_loader: frame-level model plus directed vectors.
module tb_operand_pair_loader;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         ser_in = 1'b0;
    logic         ser_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic         lsb_or;
    logic         out_valid;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    operand_pair_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .a_out     (a_out),
        .b_out     (b_out),
        .lsb_or    (lsb_or),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Frame-level model: collect accepted bits, build operands when 2*W are in
    int           m_cnt = 0;
    bit           m_active = 1'b0;
    bit           m_pres = 1'b0;
    logic [2*W-1:0] m_bits = '0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         m_lsb = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_active = 0; m_pres = 0;
            m_a = '0; m_b = '0; m_lsb = 1'b0;
        end else if (abort) begin
            m_cnt = 0; m_active = 0; m_pres = 0;
        end else if (m_pres) begin
            if (out_ready) m_pres = 0;
        end else if (m_active) begin
            if (ser_valid) begin
                m_bits[m_cnt] = ser_in;
                m_cnt++;
                if (m_cnt == 2 * W) begin
                    for (int i = 0; i < W; i++) begin
                        m_a[i] = m_bits[i];
                        m_b[i] = m_bits[W + i];
                    end
                    m_lsb    = m_a[0] | m_b[0];
                    m_pres   = 1;
                    m_active = 0;
                end
            end
        end else if (start) begin
            m_active = 1;
            m_cnt    = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_out", 32'(a_out), 32'(m_a));
            chk("b_out", 32'(b_out), 32'(m_b));
            chk("lsb_or", 32'(lsb_or), 32'(m_lsb));
            chk("out_valid", 32'(out_valid), 32'(m_pres));
            chk("busy", 32'(busy), 32'(m_active | m_pres));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] gaps, input int start_at);
        logic [2*W-1:0] stream;
        stream = {b, a};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            if (gaps[i]) begin
                ser_valid = 1'b0;
                ser_in    = 1'($urandom);
                step();
            end
            ser_valid = 1'b1;
            ser_in    = stream[i];
            start     = (i == start_at);
            step();
        end
        ser_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_valid_low", 32'(out_valid), 32'd0);
        chk("hs_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2*W-1:0] gaps;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", 32'(a_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // ser_valid without start is ignored in IDLE
        ser_valid = 1'b1; ser_in = 1'b1;
        repeat (3) step();
        ser_valid = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);

        // Contiguous frame, valid one cycle after the last bit
        send_frame(8'h75, 8'h56, '0, -1);
        chk("f1_valid_lat", 32'(out_valid), 32'd1);
        chk("f1_a", 32'(a_out), 32'h75);
        chk("f1_b", 32'(b_out), 32'h56);
        chk("f1_lsb", 32'(lsb_or), 32'd1);
        handshake();
        chk("f1_a_kept", 32'(a_out), 32'h75);

        // Frame with three gaps
        gaps = '0;
        while ($countones(gaps) < 3) gaps[$urandom_range(0, 2 * W - 1)] = 1'b1;
        send_frame(8'h74, 8'h56, gaps, -1);
        chk("f2_valid_lat", 32'(out_valid), 32'd1);
        chk("f2_a", 32'(a_out), 32'h74);
        chk("f2_lsb", 32'(lsb_or), 32'd0);
        handshake();

        // Backpressure: hold 5 cycles
        send_frame(8'hA5, 8'h3C, '0, -1);
        repeat (5) step();
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_a", 32'(a_out), 32'hA5);
        chk("bp_b", 32'(b_out), 32'h3C);
        chk("bp_lsb", 32'(lsb_or), 32'd1);
        handshake();

        // start in SHIFT_B and in the handshake cycle is ignored
        send_frame(8'h12, 8'h34, '0, 11);
        chk("sb_a", 32'(a_out), 32'h12);
        chk("sb_b", 32'(b_out), 32'h34);
        chk("sb_lsb", 32'(lsb_or), 32'd0);
        start = 1'b1;
        handshake();
        start = 1'b0;
        step();
        chk("sb_no_restart", 32'(busy), 32'd0);

        // Abort after 10 bits keeps previous pair
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ser_valid = 1'b1; ser_in = 1'(i); step();
        end
        ser_valid = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_valid", 32'(out_valid), 32'd0);
        chk("ab_a_kept", 32'(a_out), 32'h12);
        chk("ab_b_kept", 32'(b_out), 32'h34);
        send_frame(8'h81, 8'h02, '0, -1);
        chk("ab_new_a", 32'(a_out), 32'h81);
        chk("ab_new_b", 32'(b_out), 32'h02);
        chk("ab_new_lsb", 32'(lsb_or), 32'd1);
        handshake();

        // Reset mid SHIFT_A
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ser_valid = 1'b1; ser_in = 1'b1; step();
        end
        ser_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_a", 32'(a_out), 32'd0);
        chk("mr_b", 32'(b_out), 32'd0);
        chk("mr_lsb", 32'(lsb_or), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ser_valid = 1'($urandom); ser_in = 1'($urandom); step();
        end
        ser_valid = 1'b0;
        chk("mr_no_valid", 32'(out_valid), 32'd0);
        chk("mr_idle", 32'(busy), 32'd0);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
